// File: rtl/pattern_bank_pkg.sv
// Shared constants, word/pointer types and the parity helper for the pattern bank.
package pattern_pkg;

    localparam int DEF_NUM_BUFS = 8;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_WIDTH    = 8;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W    = 64;

    typedef logic [DEF_WIDTH-1:0]         word_t;
    typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;

    // Bit that makes the total count of ones in {data, bit} even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pattern_bank_if.sv
// Serial load, commit and field read signals of pattern_bank.
// PATTERN_BANK_PARITY_EN adds inj_par and parity_err.
interface pattern_bank_if import pattern_pkg::*; #(
    parameter int NUM_BUFS = DEF_NUM_BUFS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH
);
    localparam int AW = $clog2(NUM_BUFS);
    localparam int PW = $clog2(DEPTH);

    logic                ssel;
    logic [AW-1:0]       saddr;
    logic                sin;
    logic                commit;
    logic [AW-1:0]       bufp;
    logic [PW-1:0]       fieldp;
    logic [WIDTH-1:0]    field_byte;
    logic                load_done;
    logic [NUM_BUFS-1:0] bank_sel;

`ifdef PATTERN_BANK_PARITY_EN
    logic                inj_par;
    logic                parity_err;

    modport master (
        output ssel, saddr, sin, commit, bufp, fieldp, inj_par,
        input  field_byte, load_done, bank_sel, parity_err
    );
    modport slave (
        input  ssel, saddr, sin, commit, bufp, fieldp, inj_par,
        output field_byte, load_done, bank_sel, parity_err
    );
`else
    modport master (
        output ssel, saddr, sin, commit, bufp, fieldp,
        input  field_byte, load_done, bank_sel
    );
    modport slave (
        input  ssel, saddr, sin, commit, bufp, fieldp,
        output field_byte, load_done, bank_sel
    );
`endif

endinterface

// File: rtl/pattern_bank_ser.sv
// Serial scan engine: frame detect, bit/word counting, readback shift register
// and the shadow-bank write request.
module pattern_bank_ser import pattern_pkg::*; #(
    parameter int NUM_BUFS = DEF_NUM_BUFS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic                         ssel,
    input  logic [$clog2(NUM_BUFS)-1:0]  saddr,
    input  logic                         sin,
    input  logic                         commit,
    input  logic [WIDTH-1:0]             rd_word,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic                         shreg_msb,
    output logic                         wr_en,
    output logic [$clog2(NUM_BUFS)-1:0]  wr_buf,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [WIDTH-1:0]             wr_data,
    output logic                         load_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);

    logic             ssel_q;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             load_done_q, load_done_d;

    logic             frame_start;
    logic             shifting;
    logic             word_end;
    logic             wptr_last;
    logic [PW-1:0]    wptr_inc;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        frame_start = ssel && !ssel_q;
        shifting    = ssel && ssel_q;
        shifted     = {shreg_q[WIDTH-2:0], sin};
        word_end    = shifting && (bitcnt_q == BW'(WIDTH-1));
        wptr_last   = (wptr_q == PW'(DEPTH-1));
        wptr_inc    = wptr_last ? '0 : wptr_q + 1'b1;

        bitcnt_d    = bitcnt_q;
        wptr_d      = wptr_q;
        shreg_d     = shreg_q;
        load_done_d = 1'b0;
        rd_ptr      = '0;

        if (frame_start) begin
            bitcnt_d = '0;
            wptr_d   = '0;
            shreg_d  = rd_word;
        end else if (shifting) begin
            shreg_d  = shifted;
            bitcnt_d = bitcnt_q + 1'b1;
            if (word_end) begin
                // Reload the next shadow word so sout keeps streaming old contents.
                bitcnt_d    = '0;
                wptr_d      = wptr_inc;
                rd_ptr      = wptr_inc;
                shreg_d     = rd_word;
                load_done_d = wptr_last;
            end
        end

        // A commit still lets a completing word land, but drops any partial one.
        if (commit) begin
            bitcnt_d = '0;
            wptr_d   = '0;
        end
    end

    always_ff @(posedge sclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ssel_q      <= 1'b0;
            bitcnt_q    <= '0;
            wptr_q      <= '0;
            shreg_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            ssel_q      <= ssel;
            bitcnt_q    <= bitcnt_d;
            wptr_q      <= wptr_d;
            shreg_q     <= shreg_d;
            load_done_q <= load_done_d;
        end
    end

    assign wr_en     = word_end;
    assign wr_buf    = saddr;
    assign wr_ptr    = wptr_q;
    assign wr_data   = shifted;
    assign shreg_msb = shreg_q[WIDTH-1];
    assign load_done = load_done_q;

endmodule

// File: rtl/pattern_bank.sv
// Double-banked pattern buffers: serial loads hit the shadow bank, commit swaps banks.
// Define PATTERN_BANK_PARITY_EN for per-word even parity with parity_err readback.
module pattern_bank import pattern_pkg::*; #(
    parameter int NUM_BUFS = DEF_NUM_BUFS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic           sclk,
    input  logic           rst,
    pattern_bank_if.slave  bus,
    // Tri-state pin, kept outside the interface bundle.
    output wire            sout
);
    localparam int AW = $clog2(NUM_BUFS);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [NUM_BUFS][2][DEPTH];
    logic [NUM_BUFS-1:0] bank_sel_q;
    logic [WIDTH-1:0]    field_byte_q;

    logic                wr_en;
    logic [AW-1:0]       wr_buf;
    logic [PW-1:0]       wr_ptr;
    logic [WIDTH-1:0]    wr_data;
    logic                wr_bank;
    logic [PW-1:0]       rd_ptr;
    logic [WIDTH-1:0]    rd_word;
    logic                shreg_msb;
    logic                load_done;
    logic                rd_hit;
    logic [WIDTH-1:0]    act_word;

    pattern_bank_ser #(
        .NUM_BUFS (NUM_BUFS),
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH)
    ) u_ser (
        .sclk      (sclk),
        .rst       (rst),
        .ssel      (bus.ssel),
        .saddr     (bus.saddr),
        .sin       (bus.sin),
        .commit    (bus.commit),
        .rd_word   (rd_word),
        .rd_ptr    (rd_ptr),
        .shreg_msb (shreg_msb),
        .wr_en     (wr_en),
        .wr_buf    (wr_buf),
        .wr_ptr    (wr_ptr),
        .wr_data   (wr_data),
        .load_done (load_done)
    );

    always_comb begin
        rd_word  = mem_q[bus.saddr][~bank_sel_q[bus.saddr]][rd_ptr];
        wr_bank  = ~bank_sel_q[wr_buf];
        rd_hit   = ({1'b0, bus.fieldp} < (PW+1)'(DEPTH)) &&
                   ({1'b0, bus.bufp}   < (AW+1)'(NUM_BUFS));
        act_word = '0;
        if (rd_hit) begin
            act_word = mem_q[bus.bufp][bank_sel_q[bus.bufp]][bus.fieldp];
        end
    end

    always_ff @(posedge sclk) begin
        // NOTE: contents must read as zero after reset, so the arrays are flops cleared here rather than an unreset RAM.
        if (rst) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                for (int k = 0; k < 2; k++) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        mem_q[b][k][d] <= '0;
                    end
                end
            end
        end else if (wr_en) begin
            mem_q[wr_buf][wr_bank][wr_ptr] <= wr_data;
        end
    end

    // The read uses pre-edge bank_sel, so a read in the commit cycle sees the old active bank.
    always_ff @(posedge sclk) begin
        if (rst) begin
            bank_sel_q   <= '0;
            field_byte_q <= '0;
        end else begin
            if (bus.commit) begin
                bank_sel_q[bus.saddr] <= ~bank_sel_q[bus.saddr];
            end
            field_byte_q <= act_word;
        end
    end

`ifdef PATTERN_BANK_PARITY_EN
    logic par_q [NUM_BUFS][2][DEPTH];
    logic inj_pend_q;
    logic parity_err_q;
    logic act_par;

    always_comb begin
        act_par = 1'b0;
        if (rd_hit) begin
            act_par = par_q[bus.bufp][bank_sel_q[bus.bufp]][bus.fieldp];
        end
    end

    // inj_par arms a one-shot inversion consumed by the next shadow write.
    always_ff @(posedge sclk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                for (int k = 0; k < 2; k++) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        par_q[b][k][d] <= 1'b0;
                    end
                end
            end
            inj_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                par_q[wr_buf][wr_bank][wr_ptr] <=
                    even_parity(PAR_MAX_W'(wr_data)) ^ (inj_pend_q | bus.inj_par);
                inj_pend_q <= 1'b0;
            end else if (bus.inj_par) begin
                inj_pend_q <= 1'b1;
            end
            parity_err_q <= rd_hit & (act_par ^ even_parity(PAR_MAX_W'(act_word)));
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.field_byte = field_byte_q;
    assign bus.load_done  = load_done;
    assign bus.bank_sel   = bank_sel_q;
    assign sout           = bus.ssel ? shreg_msb : 1'bz;

endmodule
